// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle controller for unsigned RV32M multiply/divide in the EX stage.
//   An accepted M-op is captured and run through a 32-step shift-add
//   multiply or restoring divide. The pipeline is held with stall_o until
//   the result is ready. The result is then presented for one cycle with
//   done_o.
//
// Ports
//   clk       in   1     system clock, rising edge
//   reset     in   1     synchronous, active-high
//   start_i   in   1     EX holds a valid M-op (level, held while stalled)
//   flush_i   in   1     EX instruction squashed
//   funct3_i  in   3     000 MUL, 011 MULHU, 101 DIVU, 111 REMU
//   rs1_i     in   XLEN  multiplicand / dividend
//   rs2_i     in   XLEN  multiplier / divisor
//   stall_o   out  1     freeze front end, bubble EX/MEM
//   busy_o    out  1     FSM not IDLE
//   done_o    out  1     result_o valid this cycle
//   result_o  out  XLEN  operation result (holds until next DONE or reset)
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Only the four unsigned M-ops are handled here.
  function automatic logic is_supported(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One shift-add step on {hi,lo}; the 33rd bit of the sum keeps the carry
  // so it can be shifted down into hi[XLEN-1].
  function automatic logic [2*XLEN-1:0] mul_step(
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo,
    input logic [XLEN-1:0] mcand
  );
    logic [XLEN:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    return {sum[XLEN:1], sum[0], lo[XLEN-1:1]};
  endfunction

  // One restoring-divide step on {rem,quot}. The shifted remainder needs
  // XLEN+1 bits; the sign of the trial difference decides the quotient bit.
  function automatic logic [2*XLEN-1:0] div_step(
    input logic [XLEN-1:0] rem,
    input logic [XLEN-1:0] quot,
    input logic [XLEN-1:0] divisor
  );
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] new_rem;
    shifted = {rem, quot[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    new_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    return {new_rem, quot[XLEN-2:0], ~trial[XLEN]};
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              op_div_r;    // 1: divide, 0: multiply
  logic              op_hi_r;     // 1: MULHU/REMU take the acc half
  logic [XLEN-1:0]   opb_r;       // multiplicand or divisor
  logic [XLEN-1:0]   acc_r;       // product hi / partial remainder
  logic [XLEN-1:0]   lo_r;        // product lo / quotient
  logic [XLEN-1:0]   result_r;

  logic              stall_s;
  logic              capture_s;
  logic              div_zero_s;
  logic              step_s;
  logic              finish_s;
  logic [2*XLEN-1:0] step_res_s;
  logic [XLEN-1:0]   next_acc_s;
  logic [XLEN-1:0]   next_lo_s;
  logic [XLEN-1:0]   final_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and control strobes; flush outranks start.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    capture_s    = 1'b0;
    div_zero_s   = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_i) begin
          next_state_s = ST_IDLE;
        end else if (start_i && is_supported(funct3_i)) begin
          stall_s   = 1'b1;
          capture_s = 1'b1;
          if (funct3_i[2] && (rs2_i == {XLEN{1'b0}})) begin
            div_zero_s   = 1'b1;
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          next_state_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
          step_s  = 1'b1;
          if (cnt_r == {CNT_W{1'b1}}) begin
            finish_s     = 1'b1;
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Iteration arithmetic on the captured operands.
  always_comb begin
    if (op_div_r) begin
      step_res_s = div_step(acc_r, lo_r, opb_r);
    end else begin
      step_res_s = mul_step(acc_r, lo_r, opb_r);
    end
    next_acc_s = step_res_s[2*XLEN-1:XLEN];
    next_lo_s  = step_res_s[XLEN-1:0];
    final_s    = op_hi_r ? next_acc_s : next_lo_s;
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_div_r <= 1'b0;
      op_hi_r  <= 1'b0;
      opb_r    <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else if (capture_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_div_r <= funct3_i[2];
      op_hi_r  <= funct3_i[1];
      // Multiply iterates over the multiplier in lo; divide shifts the
      // dividend out of lo while the quotient shifts in.
      opb_r    <= funct3_i[2] ? rs2_i : rs1_i;
      lo_r     <= funct3_i[2] ? rs1_i : rs2_i;
      acc_r    <= {XLEN{1'b0}};
      if (div_zero_s) begin
        result_r <= funct3_i[1] ? rs1_i : {XLEN{1'b1}};
      end
    end else if (step_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      acc_r <= next_acc_s;
      lo_r  <= next_lo_s;
      if (finish_s) begin
        result_r <= final_s;
      end
    end
  end

  // Stall must react in the same cycle as start/flush, so it stays
  // combinational; the remaining outputs come straight from registers.
  assign stall_o  = stall_s & ~reset;
  assign busy_o   = (state_r != ST_IDLE);
  assign done_o   = (state_r == ST_DONE);
  assign result_o = result_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] MUL   = 3'b000;
  localparam logic [2:0] MULHU = 3'b011;
  localparam logic [2:0] DIVU  = 3'b101;
  localparam logic [2:0] REMU  = 3'b111;

  mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Issue one op, hold start while stalled, scramble inputs during RUN,
  // then check latency, result and result hold.
  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_stall);
    int stalls;
    int n;
    bit got;
    stalls = 0;
    n      = 0;
    got    = 1'b0;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    rs1_i    = a;
    rs2_i    = b;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall_o === 1'b1) stalls++;
      n++;
      @(negedge clk);
      rs1_i    = ~a;
      rs2_i    = b ^ 32'h5A5A_A5A5;
      funct3_i = f3 ^ 3'b010;
    end
    start_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: done_o never seen within 80 cycles", name);
    end
    checks++;
    if (stalls !== exp_stall) begin
      errors++;
      $display("FAIL %s_stalls: got %0d expected %0d", name, stalls, exp_stall);
    end
    checks++;
    if (n !== exp_stall) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles expected %0d", name, n, exp_stall);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++;
      $display("FAIL %s_result: got %h expected %h", name, result_o, exp_res);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp_res) begin
      errors++;
      $display("FAIL %s_hold: done=%b busy=%b result=%h expected 0 0 %h",
               name, done_o, busy_o, result_o, exp_res);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = 3'b000;
    rs1_i    = 32'd0;
    rs2_i    = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: stall=%b busy=%b done=%b result=%h expected all 0",
               stall_o, busy_o, done_o, result_o);
    end
  endtask

  task automatic test_mul();
    run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'd42, 33);
    run_op("mul_ffx2", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    run_op("mulhu_ffxff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhu_8x4", MULHU, 32'h8000_0000, 32'd4, 32'h0000_0002, 33);
  endtask

  task automatic test_div();
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_5_9", DIVU, 32'd5, 32'd9, 32'd0, 33);
    run_op("remu_5_9", REMU, 32'd5, 32'd9, 32'd5, 33);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_123_0", DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_123_0", REMU, 32'd123, 32'd0, 32'd123, 1);
  endtask

  task automatic test_unsupported();
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b001;
    rs1_i    = 32'd5;
    rs2_i    = 32'd3;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL unsupported_stall: got %b expected 0", stall_o);
    end
    @(negedge clk);
    funct3_i = 3'b100;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL unsupported_idle: busy=%b stall=%b expected 0 0", busy_o, stall_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL unsupported_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = MUL;
    rs1_i    = 32'd2;
    rs2_i    = 32'd2;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall: got %b expected 0", stall_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_flush_run();
    int bad;
    bad = 0;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = MUL;
    rs1_i    = 32'd12;
    rs2_i    = 32'd13;
    // cycle 0 is IDLE, cycle k+1 is RUN with cnt=k; stop at cnt=10
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_run_same_cycle: stall=%b busy=%b expected 0 1", stall_o, busy_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_idle: busy=%b stall=%b done=%b expected 0 0 0",
               busy_o, stall_o, done_o);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL flush_run_no_done: got %0d done cycles expected 0", bad);
    end
    run_op("mul_3x3", MUL, 32'd3, 32'd3, 32'd9, 33);
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = DIVU;
    rs1_i    = 32'd123;
    rs2_i    = 32'd0;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_stall: got %b expected 1", stall_o);
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++;
    if (done_o !== 1'b1 || result_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL flush_done_result: done=%b result=%h expected 1 ffffffff", done_o, result_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_after: busy=%b done=%b expected 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = MUL;
    rs1_i    = 32'd1234;
    rs2_i    = 32'd5678;
    repeat (21) @(negedge clk);
    reset   = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: stall=%b busy=%b done=%b result=%h expected all 0",
               stall_o, busy_o, done_o, result_o);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int d;
    int stalls;
    got    = 1'b0;
    d      = 0;
    stalls = 0;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = DIVU;
    rs1_i    = 32'd9;
    rs2_i    = 32'd3;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got || result_o !== 32'd3) begin
      errors++;
      $display("FAIL b2b_divu: done=%b result=%h expected 1 00000003", got, result_o);
    end
    // pipeline advances in DONE: the next M-op appears in EX now
    funct3_i = REMU;
    rs1_i    = 32'd9;
    rs2_i    = 32'd4;
    got      = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      d++;
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall_o === 1'b1) stalls++;
    end
    start_i = 1'b0;
    checks++;
    if (!got || result_o !== 32'd1) begin
      errors++;
      $display("FAIL b2b_remu: done=%b result=%h expected 1 00000001", got, result_o);
    end
    checks++;
    if (d !== 34 || stalls !== 33) begin
      errors++;
      $display("FAIL b2b_spacing: done-to-done %0d stalls %0d expected 34 33", d, stalls);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_unsupported();
    test_flush_idle();
    test_flush_run();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
